mmio_to_avst_cmd: RTL

//  Upstream feeder for the AVST-to-AVMM slave bridge. Turns host MMIO requests (no backpressure, tid-tagged,
//  DW addressed) into the packed AVST command {is_read,is_32bit,addr,write_data}, buffers them in order,

---
 rtl/mmio_cmd_pkg.sv | 43 ++++
 rtl/mmio_to_avst_cmd_if.sv | 47 ++++
 rtl/mmio_sync_fifo.sv | 55 +++++
 rtl/mmio_to_avst_cmd.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mmio_cmd_pkg.sv
// mmio_cmd_pkg
//   Shared types for the MMIO -> AVST command feeder.
//   t_avst_cmd  : packed command word {is_read,is_32bit,addr,write_data} sent to the bridge
//   t_cmd_entry : command FIFO entry (command plus the read tid that rides alongside it)
//   t_rd_tag    : read tag FIFO entry {tid,hi_lane,is_32bit}
//   ERR_*       : bit positions inside err_flags
//   rsp_lane()  : picks the returned 32-bit lane (or full 64 bits) for an MMIO read response
//   The struct layouts use the widths below; the top-level parameters default to these.
package mmio_cmd_pkg;

   localparam int CMD_ADDR_W = 18;
   localparam int CMD_DATA_W = 64;
   localparam int CMD_TID_W  = 9;

   localparam int ERR_CMD_OVF    = 0;
   localparam int ERR_WR_RD_COLL = 1;
   localparam int ERR_UNEXP_RSP  = 2;

   typedef struct packed {
      logic                  is_read;
      logic                  is_32bit;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] write_data;
   } t_avst_cmd;

   typedef struct packed {
      logic [CMD_TID_W-1:0] tid;
      t_avst_cmd            cmd;
   } t_cmd_entry;

   typedef struct packed {
      logic [CMD_TID_W-1:0] tid;
      logic                 hi_lane;
      logic                 is_32bit;
   } t_rd_tag;

   // 32-bit reads return the addressed lane zero-extended; 64-bit reads pass through.
   function automatic logic [CMD_DATA_W-1:0] rsp_lane(t_rd_tag tag, logic [CMD_DATA_W-1:0] d);
      if (!tag.is_32bit) return d;
      return tag.hi_lane ? {32'h0, d[63:32]} : {32'h0, d[31:0]};
   endfunction

endpackage

// File: rtl/mmio_to_avst_cmd_if.sv
// mmio_to_avst_cmd_if
//   Bundles the MMIO request/response, AVST command and read-data signals of the feeder.
//   modport slave  : the feeder (mmio_to_avst_cmd)
//   modport master : the surrounding host / bridge environment
interface mmio_to_avst_cmd_if #(
   parameter int AVMM_ADDR_WIDTH = 18,
   parameter int TID_WIDTH       = 9
);
   // host MMIO request
   logic                        mmio_wr_valid;
   logic                        mmio_rd_valid;
   logic [AVMM_ADDR_WIDTH-3:0]  mmio_addr;
   logic                        mmio_len64;
   logic [TID_WIDTH-1:0]        mmio_tid;
   logic [63:0]                 mmio_wdata;
   // AVST command to bridge
   logic [AVMM_ADDR_WIDTH+65:0] cmd_data;
   logic                        cmd_valid;
   logic                        cmd_ready;
   // read data from bridge
   logic [63:0]                 rsp_data;
   logic                        rsp_valid;
   logic                        rsp_ready;
   // MMIO read response
   logic                        mmio_rsp_valid;
   logic [TID_WIDTH-1:0]        mmio_rsp_tid;
   logic [63:0]                 mmio_rsp_data;

   modport slave (
      input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len64, mmio_tid, mmio_wdata,
      output cmd_data, cmd_valid,
      input  cmd_ready,
      input  rsp_data, rsp_valid,
      output rsp_ready,
      output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
   );

   modport master (
      output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len64, mmio_tid, mmio_wdata,
      input  cmd_data, cmd_valid,
      output cmd_ready,
      output rsp_data, rsp_valid,
      input  rsp_ready,
      input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
   );

endinterface

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo
//   Single-clock FIFO, output taken straight from the storage flops.
//   clk, reset_n : clock, synchronous active-low reset (flushes pointers)
//   push, din    : write request / data; accepted when not full or when popping the same cycle
//   pop, dout    : read request / head entry (valid while !empty)
//   full, empty  : occupancy flags
//   DEPTH must be a power of two (pointers wrap naturally).
module mmio_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count;
   logic             do_push, do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_to_avst_cmd.sv
// mmio_to_avst_cmd
//   Upstream feeder for the AVST-to-AVMM slave bridge. Converts MMIO requests into packed AVST
//   commands, queues them in order, limits reads in flight and tags returned read data with its tid.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : MMIO request, AVST command, bridge read data and MMIO response signals
//   err_flags    : sticky [0] command overflow, [1] write+read collision, [2] unexpected response
//   wr_cnt,rd_cnt: accepted write / read commands (only when MMIO_CMD_STATS_EN is defined)
//   Optional feature macro: MMIO_CMD_STATS_EN.
module mmio_to_avst_cmd
   import mmio_cmd_pkg::*;
#(
   parameter int AVMM_ADDR_WIDTH    = CMD_ADDR_W,
   parameter int AVMM_DATA_WIDTH    = CMD_DATA_W,
   parameter int TID_WIDTH          = CMD_TID_W,
   parameter int CMD_FIFO_DEPTH     = 8,
   parameter int MAX_RD_OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   mmio_to_avst_cmd_if.slave   bus,
   output logic [2:0]          err_flags
`ifdef MMIO_CMD_STATS_EN
   ,
   output logic [31:0]         wr_cnt,
   output logic [31:0]         rd_cnt
`endif
);

   localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING) + 1;

   logic [AVMM_ADDR_WIDTH-1:0] req_addr;
   logic [AVMM_DATA_WIDTH-1:0] req_wdata;
   logic [TID_WIDTH-1:0]       req_tid;
   logic                       req_wr, req_rd, req_any, collide, overflow;
   t_cmd_entry                 req_ent, head_ent;
   logic                       cmd_full, cmd_empty, cmd_pop;
   t_rd_tag                    tag_in, tag_out;
   logic                       tag_full, tag_empty, tag_push;
   logic                       rsp_take, rsp_fire, rsp_unexp, rd_throttled;
   logic [CNT_W-1:0]           rd_outst;

   // A write wins a same-cycle write/read collision; the read is dropped.
   assign req_wr   = bus.mmio_wr_valid;
   assign req_rd   = bus.mmio_rd_valid & ~bus.mmio_wr_valid;
   assign collide  = bus.mmio_wr_valid & bus.mmio_rd_valid;
   assign req_any  = req_wr | req_rd;
   assign req_addr = {bus.mmio_addr, 2'b00};
   assign req_tid  = bus.mmio_tid;

   // 32-bit writes are replicated to both lanes so the bridge byteenable picks the right one.
   always_comb begin
      req_wdata = '0;
      if (!req_rd) req_wdata = bus.mmio_len64 ? bus.mmio_wdata : {2{bus.mmio_wdata[31:0]}};
   end

   always_comb begin
      req_ent                = '0;
      req_ent.tid            = req_tid;
      req_ent.cmd.is_read    = req_rd;
      req_ent.cmd.is_32bit   = ~bus.mmio_len64;
      req_ent.cmd.addr       = req_addr;
      req_ent.cmd.write_data = req_wdata;
   end

   mmio_sync_fifo #(
      .WIDTH ($bits(t_cmd_entry)),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (req_any),
      .din     (req_ent),
      .pop     (cmd_pop),
      .dout    (head_ent),
      .full    (cmd_full),
      .empty   (cmd_empty)
   );

   // Head read waits while the read budget is used up; everything behind it waits too.
   assign rd_throttled  = head_ent.cmd.is_read &
                          ((rd_outst == CNT_W'(MAX_RD_OUTSTANDING)) | tag_full);
   assign bus.cmd_valid = ~cmd_empty & ~rd_throttled;
   assign bus.cmd_data  = bus.cmd_valid ? head_ent.cmd : t_avst_cmd'('0);
   assign cmd_pop       = bus.cmd_valid & bus.cmd_ready;
   assign overflow      = req_any & cmd_full & ~cmd_pop;

   assign tag_push        = cmd_pop & head_ent.cmd.is_read;
   assign tag_in.tid      = head_ent.tid;
   assign tag_in.hi_lane  = head_ent.cmd.addr[2];
   assign tag_in.is_32bit = head_ent.cmd.is_32bit;

   mmio_sync_fifo #(
      .WIDTH ($bits(t_rd_tag)),
      .DEPTH (MAX_RD_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tag_push),
      .din     (tag_in),
      .pop     (rsp_fire),
      .dout    (tag_out),
      .full    (tag_full),
      .empty   (tag_empty)
   );

   // A response with no tag queued (e.g. one still in flight across a reset) is discarded.
   assign rsp_take  = bus.rsp_valid & bus.rsp_ready;
   assign rsp_fire  = rsp_take & ~tag_empty;
   assign rsp_unexp = rsp_take & tag_empty;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_outst           <= '0;
         bus.rsp_ready      <= 1'b0;
         bus.mmio_rsp_valid <= 1'b0;
         bus.mmio_rsp_tid   <= '0;
         bus.mmio_rsp_data  <= '0;
         err_flags          <= '0;
      end else begin
         bus.rsp_ready      <= 1'b1;
         bus.mmio_rsp_valid <= rsp_fire;
         if (rsp_fire) begin
            bus.mmio_rsp_tid  <= tag_out.tid;
            bus.mmio_rsp_data <= rsp_lane(tag_out, bus.rsp_data);
         end
         case ({tag_push, rsp_fire})
            2'b10:   rd_outst <= rd_outst + 1'b1;
            2'b01:   rd_outst <= rd_outst - 1'b1;
            default: rd_outst <= rd_outst;
         endcase
         if (overflow)  err_flags[ERR_CMD_OVF]    <= 1'b1;
         if (collide)   err_flags[ERR_WR_RD_COLL] <= 1'b1;
         if (rsp_unexp) err_flags[ERR_UNEXP_RSP]  <= 1'b1;
      end
   end

`ifdef MMIO_CMD_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else if (cmd_pop) begin
         if (head_ent.cmd.is_read) rd_cnt <= rd_cnt + 1'b1;
         else                      wr_cnt <= wr_cnt + 1'b1;
      end
   end
`endif

endmodule
